// File: rtl/hdb3_pkg.sv
// Shared HDB3 definitions: symbol codes used by the substitution stage,
// the polarity stage and the decoder.
package hdb3_pkg;
    localparam logic [1:0] CODE_ZERO = 2'b00;
    localparam logic [1:0] CODE_ONE  = 2'b01;
    localparam logic [1:0] CODE_B    = 2'b10;
    localparam logic [1:0] CODE_V    = 2'b11;
    localparam int         ZERO_RUN  = 4;
endpackage

// File: rtl/hdb3_vb_insert.sv
// HDB3 encoder front end: replaces each run of four zeros with 000V or B00V
// and emits one unsigned 2-bit symbol code per enabled bit slot.
module hdb3_vb_insert
    import hdb3_pkg::*;
#(
    parameter logic INIT_PARITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       data_in,
    output logic [1:0] data_out,
    output logic       out_valid
);

    logic [ZERO_RUN-1:0][1:0] sr;
    logic [1:0]               zcnt;
    logic                     par;
    logic [2:0]               fcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            zcnt      <= '0;
            par       <= INIT_PARITY;
            fcnt      <= '0;
            data_out  <= CODE_ZERO;
            out_valid <= 1'b0;
        end else if (en) begin
            data_out  <= sr[3];
            sr[3]     <= sr[2];
            sr[2]     <= sr[1];
            sr[1]     <= sr[0];
            out_valid <= (fcnt == 3'd4);
            if (fcnt != 3'd4)
                fcnt <= fcnt + 3'd1;

            if (data_in) begin
                sr[0] <= CODE_ONE;
                zcnt  <= '0;
                par   <= ~par;
            end else if (zcnt != 2'd3) begin
                sr[0] <= CODE_ZERO;
                zcnt  <= zcnt + 2'd1;
            end else begin
                // Fourth zero: the run's first zero is shifting into sr[3];
                // it becomes B when an even number of pulses preceded this V.
                sr[0] <= CODE_V;
                sr[3] <= par ? CODE_ZERO : CODE_B;
                zcnt  <= '0;
                par   <= 1'b0;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hdb3_vb_insert.sv
// Directed bench for hdb3_vb_insert: a vector table of chained scenarios
// plus a hand-written sequence with a toggling bit-slot strobe.
module tb_hdb3_vb_insert;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       data_in = 1'b0;
    logic [1:0] data_out;
    logic       out_valid;

    int n_vec  = 0;
    int n_fail = 0;

    hdb3_vb_insert #(.INIT_PARITY(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       din;
        logic [1:0] exp_d;
        logic       exp_v;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic e, input logic d,
                                input logic [1:0] x, input logic v);
        vec_t t;
        t.rst = r; t.en = e; t.din = d; t.exp_d = x; t.exp_v = v;
        tbl.push_back(t);
    endfunction

    task automatic apply(input string name, input logic r, input logic e, input logic d,
                         input logic [1:0] x, input logic v);
        rst = r; en = e; data_in = d;
        @(posedge clk);
        #1;
        n_vec++;
        if (data_out !== x || out_valid !== v) begin
            n_fail++;
            $display("FAIL %s #%0d: data_out=%b out_valid=%b, expected %b %b",
                     name, n_vec, data_out, out_valid, x, v);
        end
    endtask

    // Expected codes for stream 1,0,0,0,0,1,1,1,1,1 (odd parity -> 000V)
    logic       din_a [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0] exp_a [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01};
    logic       vld_a [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        // Scenario 1: 1,0,0,0,0,1 -> 01,00,00,00,11,01
        add(1, 1, 0, 2'b00, 0);
        for (int i = 0; i < 10; i++) add(0, 1, din_a[i], exp_a[i], vld_a[i]);

        // Scenario 2: four zeros from reset -> B00V
        add(1, 1, 1, 2'b00, 0);
        add(0, 1, 0, 2'b00, 0); add(0, 1, 0, 2'b00, 0);
        add(0, 1, 0, 2'b00, 0); add(0, 1, 0, 2'b00, 0);
        add(0, 1, 1, 2'b10, 1); add(0, 1, 1, 2'b00, 1);
        add(0, 1, 1, 2'b00, 1); add(0, 1, 1, 2'b11, 1);
        add(0, 1, 1, 2'b01, 1);

        // Scenario 3: 1,1,0,0,0,0 -> 01,01,10,00,00,11
        add(1, 1, 0, 2'b00, 0);
        add(0, 1, 1, 2'b00, 0); add(0, 1, 1, 2'b00, 0);
        add(0, 1, 0, 2'b00, 0); add(0, 1, 0, 2'b00, 0);
        add(0, 1, 0, 2'b01, 1); add(0, 1, 0, 2'b01, 1);
        add(0, 1, 1, 2'b10, 1); add(0, 1, 1, 2'b00, 1);
        add(0, 1, 1, 2'b00, 1); add(0, 1, 1, 2'b11, 1);

        // Scenario 4: twelve zeros -> B00V three times
        add(1, 1, 1, 2'b00, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 2'b00, 0);
        for (int g = 0; g < 3; g++) begin
            add(0, 1, (g == 2), 2'b10, 1);
            add(0, 1, (g == 2), 2'b00, 1);
            add(0, 1, (g == 2), 2'b00, 1);
            add(0, 1, (g == 2), 2'b11, 1);
        end

        // Scenario 6: 1,0,0 then reset drops the partial run; next run is B00V
        add(1, 1, 0, 2'b00, 0);
        add(0, 1, 1, 2'b00, 0); add(0, 1, 0, 2'b00, 0); add(0, 1, 0, 2'b00, 0);
        add(1, 1, 0, 2'b00, 0);
        add(0, 1, 0, 2'b00, 0); add(0, 1, 0, 2'b00, 0);
        add(0, 1, 0, 2'b00, 0); add(0, 1, 0, 2'b00, 0);
        add(0, 1, 1, 2'b10, 1); add(0, 1, 1, 2'b00, 1);
        add(0, 1, 1, 2'b00, 1); add(0, 1, 1, 2'b11, 1);
        add(0, 1, 1, 2'b01, 1);

        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i])
            apply("table", tbl[i].rst, tbl[i].en, tbl[i].din, tbl[i].exp_d, tbl[i].exp_v);

        // Scenario 5: en toggling; disabled edges see data_in=0 and must hold
        apply("en_rst", 1, 1, 1, 2'b00, 0);
        for (int i = 0; i < 10; i++) begin
            apply("en_on",  0, 1, din_a[i], exp_a[i], vld_a[i]);
            apply("en_off", 0, 0, 1'b0,     exp_a[i], 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
